// File: rtl/rx_pkg.sv
// Shared constants for the UART receive controller: FSM encoding, frame
// geometry defaults and the parity mode used when RX_PARITY_EN is defined.
package rx_pkg;

    // Data bits per frame (LSB first) unless overridden at instantiation.
    localparam int DATA_BITS_DEF = 8;

    // Nominal CLK cycles per bit: 500 kHz / 9600 baud.
    localparam int BPS_T = 52;

    // Parity mode: 0 selects even parity, 1 selects odd parity.
    localparam logic PARITY_ODD = 1'b0;

    // Receiver FSM encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // A parity check fails when the XOR over data and parity bit does not
    // match the selected mode (0 for even, 1 for odd).
    function automatic logic parity_fail(input logic data_xor, input logic par_bit);
        return (data_xor ^ par_bit) != PARITY_ODD;
    endfunction

endpackage

// File: rtl/rx_sync_edge_module.sv
// Metastability synchroniser for the raw serial line followed by a
// high-to-low detector. Flops reset to 1 so an idle line never looks like
// a start edge coming out of reset.
module rx_sync_edge_module #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic RX_Pin_In,
    output logic rx_sync,
    output logic H2L_Sig
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous line through the synchroniser chain and keep
    // one extra copy of the synchronised value for edge detection.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_Pin_In};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];
    assign H2L_Sig = prev_q & ~rx_sync;

endmodule

// File: rtl/rx_control_module.sv
// UART receive controller. Detects the start edge, requests the baud counter
// via Count_Sig, samples each bit on BPS_CLK, assembles the byte LSB-first and
// validates the stop bit. Define RX_PARITY_EN for 8E1 frames with a parity
// check; without it the frame is 8N1 and Parity_Err is tied low.
module rx_control_module
    import rx_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_Pin_In,
    input  logic                 Rx_En_Sig,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Frame_Err,
    output logic                 Parity_Err
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 h2l_sig;
    logic [2:0]           state_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 active_state;

    rx_sync_edge_module #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RX_Pin_In (RX_Pin_In),
        .rx_sync   (rx_sync),
        .H2L_Sig   (h2l_sig)
    );

    // States in which a disable aborts the frame; DONE exits on its own.
    assign active_state = (state_q == ST_START) || (state_q == ST_DATA) ||
                          (state_q == ST_PARITY) || (state_q == ST_STOP);

`ifdef RX_PARITY_EN
    logic par_bit_q;
    logic par_err_q;
    logic par_bad;

    assign par_bad    = parity_fail(^shift_q, par_bit_q);
    assign Parity_Err = par_err_q;
`else
    assign Parity_Err = 1'b0;
`endif

    // Frame sequencer: start qualification, bit sampling, stop check and
    // result presentation. Status pulses default low every cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            Count_Sig   <= 1'b0;
            RX_Data     <= '0;
            RX_Done_Sig <= 1'b0;
            Frame_Err   <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            RX_Done_Sig <= 1'b0;
            Frame_Err   <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (active_state && !Rx_En_Sig) begin
                // Receiver disabled mid-frame: silent abort, data preserved.
                state_q   <= ST_IDLE;
                Count_Sig <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        Count_Sig <= 1'b0;
                        if (h2l_sig && Rx_En_Sig) begin
                            state_q   <= ST_START;
                            Count_Sig <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if (BPS_CLK) begin
                            if (!rx_sync) begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end else begin
                                // Line back high at mid start bit: glitch.
                                state_q   <= ST_IDLE;
                                Count_Sig <= 1'b0;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (BPS_CLK) begin
                            shift_q   <= {rx_sync, shift_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == LAST_IDX) begin
`ifdef RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end
                    end

`ifdef RX_PARITY_EN
                    ST_PARITY: begin
                        if (BPS_CLK) begin
                            par_bit_q <= rx_sync;
                            state_q   <= ST_STOP;
                        end
                    end
`endif

                    ST_STOP: begin
                        if (BPS_CLK) begin
                            if (!rx_sync) begin
                                // Framing error wins over any parity result.
                                Frame_Err <= 1'b1;
                                state_q   <= ST_IDLE;
                                Count_Sig <= 1'b0;
`ifdef RX_PARITY_EN
                            end else if (par_bad) begin
                                par_err_q <= 1'b1;
                                state_q   <= ST_IDLE;
                                Count_Sig <= 1'b0;
`endif
                            end else begin
                                // Data and pulse appear together in DONE.
                                RX_Data     <= shift_q;
                                RX_Done_Sig <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                        end
                    end

                    ST_DONE: begin
                        state_q   <= ST_IDLE;
                        Count_Sig <= 1'b0;
                    end

                    default: begin
                        state_q   <= ST_IDLE;
                        Count_Sig <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rx_control_module.md
Name: rx_control_module

Overview:
- UART receive controller; sits directly downstream of the baud counter (rx_bps_module) and closes the loop with it.
- Detects start bit on the serial line and raises Count_Sig to start the baud counter.
- Samples each bit on the mid-bit BPS_CLK pulse, assembles the byte LSB-first, validates the stop bit, and presents RX_Data with a one-cycle RX_Done_Sig.
- Target: 500 kHz CLK, 9600 baud, 52 CLK per bit.

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first).
- SYNC_STAGES, 2, flip-flop stages in the RX_Pin_In synchroniser (minimum 2).

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  asynchronous active-low reset.
- RX_Pin_In  input  1  raw serial line, idle high, asynchronous to CLK.
- Rx_En_Sig  input  1  receive enable; frames accepted only while high.
- BPS_CLK  input  1  one-cycle mid-bit sample pulse from the baud counter.
- Count_Sig  output  1  baud counter run request; high for the whole frame.
- RX_Data  output  DATA_BITS  last good byte; held until the next good frame.
- RX_Done_Sig  output  1  one-cycle pulse when RX_Data updates.
- Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
- Parity_Err  output  1  one-cycle parity-fail pulse (see optional feature).

Behaviour:
- Interface: one clock, CLK; reset RSTn is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, shift register 0, synchroniser flops 1 (line idle).
- Synchroniser and edge detect:
  - RX_Pin_In passes through SYNC_STAGES flops.
  - H2L_Sig = previous synchronised value 1 AND current synchronised value 0. It is a one-cycle pulse.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, DONE.
- IDLE:
  - Count_Sig=0.
  - On H2L_Sig with Rx_En_Sig=1, go to START and set Count_Sig=1 on the next cycle.
  - H2L_Sig is ignored while Rx_En_Sig=0.
- START:
  - On BPS_CLK, sample the line.
  - Sample 0: go to DATA, bit index 0.
  - Sample 1: false start (glitch); go to IDLE and drop Count_Sig. No error pulse.
- DATA:
  - Each BPS_CLK shifts the synchronised line into the shift register, LSB first.
  - After DATA_BITS samples, go to PARITY (feature on) or STOP.
- STOP:
  - On BPS_CLK, sample 1: go to DONE.
  - Sample 0: pulse Frame_Err, leave RX_Data unchanged, go to IDLE.
- DONE (one cycle):
  - Load RX_Data from the shift register and pulse RX_Done_Sig.
  - Drop Count_Sig, go to IDLE.
- Count_Sig always falls on the cycle the FSM enters IDLE. The baud counter therefore restarts from 0 on the next frame.
- Mid-frame disable: Rx_En_Sig=0 in any non-IDLE state aborts to IDLE next cycle. Count_Sig=0, no pulses, RX_Data unchanged.
- BPS_CLK is ignored in IDLE and DONE.
- Latency: first sample ~27 CLK after Count_Sig rises (mid start bit). RX_Done_Sig is 1 cycle after the stop-bit BPS_CLK.
- Back-to-back frames: a start edge is accepted on the cycle after DONE or after a Frame_Err return.
- RX_Done_Sig, Frame_Err and Parity_Err are mutually exclusive.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Frame is 8E1. PARITY state samples one bit on BPS_CLK and checks even parity over data+parity.
  - Mismatch: Parity_Err pulses for one cycle at the stop-bit decision, with no RX_Done_Sig and RX_Data unchanged. The stop bit is still checked; Frame_Err takes priority if the stop bit is low.
- Undefined: frame is 8N1, PARITY state absent, Parity_Err tied 0.

Decomposition:
- Shared package rx_pkg:
  - FSM state encoding constants.
  - DATA_BITS default.
  - Parity mode constant (even).
  - Nominal BPS_T=52 used by the bench.
- Sub-module rx_sync_edge_module: SYNC_STAGES synchroniser plus H2L detector. Outputs the synchronised line and H2L_Sig.
- Bench pairs this block with the baud counter, Count_Sig to BPS_CLK loop closed.

Test Plan:
- Byte 0xA5 in 8N1 at 52 CLK/bit, Rx_En_Sig=1:
  - Count_Sig rises within 4 CLK of the falling edge.
  - RX_Done_Sig pulses once, ~494±4 CLK after the edge.
  - RX_Data=0xA5, Count_Sig=0 next cycle.
- Glitch: line low for 10 CLK, then high → return to IDLE after the first BPS_CLK. No RX_Done_Sig, no Frame_Err, RX_Data unchanged.
- Byte 0x3C with stop bit forced 0 → Frame_Err pulses once, RX_Done_Sig stays 0, RX_Data keeps the prior 0xA5.
- Back-to-back 0x00 then 0xFF with zero idle gap → two RX_Done_Sig pulses; RX_Data reads 0x00, then 0xFF.
- Rx_En_Sig dropped during data bit 3 of 0x55 → immediate abort, Count_Sig=0, no pulses. A following 0x81 frame with Rx_En_Sig=1 is received correctly.
- RX_PARITY_EN defined, 0x07 sent with parity bit 0 (wrong) → Parity_Err pulses, no RX_Done_Sig. Same byte with parity bit 1 → RX_Done_Sig, RX_Data=0x07.
